// File: rtl/pts_pkg.sv
// ---------------------------------------------------------------------------
// pts_pkg -- shared types and constants for the flex_pts_stream serializer.
//
// Contents:
//   pts_state_e : serializer FSM states (IDLE, SHIFT)
//   PAR_BITS    : number of trailing parity bits per word (1 when the
//                 PTS_PARITY_EN macro is defined, otherwise 0)
// ---------------------------------------------------------------------------
package pts_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pts_state_e;

`ifdef PTS_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

endpackage

// File: rtl/pts_bit_counter.sv
// ---------------------------------------------------------------------------
// pts_bit_counter -- bit position counter for the serializer.
//
// Ports:
//   clk          : rising-edge clock
//   n_rst        : asynchronous active-low reset
//   clear        : synchronous clear to 0 (priority over count_en)
//   count_en     : advance one position
//   rollover_val : last count value; the next advance wraps to 0
//   count        : current position
//   terminal     : count == rollover_val (current bit is the last one)
// ---------------------------------------------------------------------------
module pts_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         count_en,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count,
    output logic         terminal
);

    assign terminal = (count == rollover_val);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/flex_pts_stream.sv
// ---------------------------------------------------------------------------
// flex_pts_stream -- parallel-to-serial streamer with a one-word holding
// register in front of the shift register (two words of buffering).
//
// Handshake: a word is accepted on a rising edge where data_valid and
// data_ready are both 1. data_ready = !hold_full, no combinational path
// from data_valid. The accepted word reaches the shift register on the
// following edge at the earliest; there is no bypass.
//
// Ports:
//   clk, n_rst   : rising-edge clock, asynchronous active-low reset
//   shift_enable : bit-rate strobe, one bit advanced per asserted cycle
//   data_in      : parallel word (NUM_BITS)
//   msb_first    : shift order for the word accepted this cycle
//   data_valid   : producer offers data_in
//   data_ready   : holding register empty
//   serial_out   : serial stream, IDLE_VAL when no word is shifting
//   busy         : a word is in the shift register
//   word_done    : one-cycle pulse after the last bit of a word
//   state_dbg    : current FSM state, for observation only
//
// Configuration: define PTS_PARITY_EN to append one even-parity bit
// (XOR of the data word) after the data bits of every word.
// ---------------------------------------------------------------------------
module flex_pts_stream
    import pts_pkg::*;
#(
    parameter int   NUM_BITS = 8,
    parameter logic IDLE_VAL = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                msb_first,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                serial_out,
    output logic                busy,
    output logic                word_done,
    output pts_state_e          state_dbg
);

    // Shift register holds the data bits plus the optional parity bit,
    // arranged so the parity bit is always the last to reach the head.
    localparam int SW = NUM_BITS + PAR_BITS;
    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(SW - 1);

    pts_state_e          state, next_state;
    logic                hold_full;
    logic [NUM_BITS-1:0] hold_data;
    logic                hold_msb;
    logic [SW-1:0]       shift_reg;
    logic [SW-1:0]       load_val;
    logic                cur_msb;
    logic                load;
    logic                advance;
    logic                done_next;
    logic                accept;
    logic [CW-1:0]       bit_cnt;
    logic                last_bit;

    pts_bit_counter #(.W(CW)) u_bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (load),
        .count_en     (advance),
        .rollover_val (LAST_IDX),
        .count        (bit_cnt),
        .terminal     (last_bit)
    );

    assign data_ready = !hold_full;
    assign accept     = data_valid && !hold_full;
    assign busy       = (state == SHIFT);
    assign state_dbg  = state;
    assign serial_out = (state == SHIFT) ? (cur_msb ? shift_reg[SW-1] : shift_reg[0])
                                         : IDLE_VAL;

    // MSB-first words shift left so the parity bit sits at bit 0;
    // LSB-first words shift right so the parity bit sits at the top.
`ifdef PTS_PARITY_EN
    assign load_val = hold_msb ? {hold_data, ^hold_data} : {^hold_data, hold_data};
`else
    assign load_val = hold_data;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                // shift_enable is irrelevant here: a held word loads at once.
                if (hold_full) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_enable) begin
                    advance = 1'b1;
                    if (last_bit) begin
                        done_next = 1'b1;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Hold register: acceptance requires it empty before the edge, and a
    // transfer requires it full, so the two never coincide.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_msb  <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= data_in;
            hold_msb  <= msb_first;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg <= {SW{IDLE_VAL}};
            cur_msb   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= done_next;
            if (load) begin
                shift_reg <= load_val;
                cur_msb   <= hold_msb;
            end else if (advance) begin
                shift_reg <= cur_msb ? {shift_reg[SW-2:0], IDLE_VAL}
                                     : {IDLE_VAL, shift_reg[SW-1:1]};
            end
        end
    end

endmodule
